// File: rtl/hyper_tg_pkg.sv
// Shared types and constants for the HyperRAM traffic generator.
// LFSR taps are used only when HYPER_TG_LFSR_EN is defined.
package hyper_tg_pkg;

    typedef enum logic [2:0] {
        StStartup,
        StIdle,
        StWrIssue,
        StWrWait,
        StRdIssue,
        StRdWait,
        StDone
    } tg_state_e;

    localparam logic [1:0] MODE_WR   = 2'd0;
    localparam logic [1:0] MODE_RD   = 2'd1;
    localparam logic [1:0] MODE_WRV  = 2'd2;
    localparam logic [1:0] MODE_LOOP = 2'd3;

    // Right-shifting Galois masks for maximal-length polynomials
    localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            16:      return LFSR_TAPS_16;
            64:      return LFSR_TAPS_64;
            default: return LFSR_TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/hyper_tg_pattern.sv
// Data pattern source: incrementing by default, Galois LFSR when
// HYPER_TG_LFSR_EN is defined. load takes priority over step.
module hyper_tg_pattern #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] value
);
`ifdef HYPER_TG_LFSR_EN
    import hyper_tg_pkg::*;

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    logic [DATA_W-1:0] next_val;
    logic [DATA_W-1:0] load_val;

    always_comb begin
        next_val = value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
        // An all-zero state would lock the LFSR
        load_val = (seed == '0) ? DATA_W'(1) : seed;
    end
`else
    logic [DATA_W-1:0] next_val;
    logic [DATA_W-1:0] load_val;

    always_comb begin
        next_val = value + DATA_W'(1);
        load_val = seed;
    end
`endif

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (step) begin
            value <= next_val;
        end
    end

endmodule

// File: rtl/hyper_traffic_gen.sv
// Write/read-verify traffic engine in front of the hyper_xface request port.
// Define HYPER_TG_LFSR_EN to switch the data pattern from increment to LFSR.
module hyper_traffic_gen
    import hyper_tg_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       START_DLY = 2000,
    parameter int unsigned       NUM_WORDS = 256,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
    parameter int unsigned       TIMEOUT   = 1023
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   seed,
    input  logic                busy,
    input  logic                rd_rdy,
    input  logic [DATA_W-1:0]   rd_d,
    output logic                wr_req,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wr_d,
    output logic [DATA_W/8-1:0] wr_byte_en,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                timeout_err
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned DLY_W = $clog2(START_DLY + 2);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 2);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = (START_DLY == 0) ? '0 : DLY_W'(START_DLY - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    tg_state_e         state_q;
    logic [DLY_W-1:0]  dly_q;
    logic [WD_W-1:0]   wd_q;
    logic [1:0]        skip_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seed_q;
    logic              got_rdy_q;
    logic              stop_q;

    logic              accept_start;
    logic              running;
    logic              wait_ok;
    logic              word_done;
    logic              last_word;
    logic              pat_load;
    logic              pat_step;
    logic [DATA_W-1:0] pat_seed;
    logic [DATA_W-1:0] pat_val;

    always_comb begin
        accept_start = start && ((state_q == StIdle) || (state_q == StDone));
        running      = (state_q == StWrIssue) || (state_q == StWrWait) ||
                       (state_q == StRdIssue) || (state_q == StRdWait);
        wait_ok      = (skip_q == 2'd0) && !busy;
        word_done    = ((state_q == StWrWait) && wait_ok) ||
                       ((state_q == StRdWait) && wait_ok && (got_rdy_q || rd_rdy));
        last_word    = (idx_q == LAST_IDX);
        // Every phase restarts the pattern from the latched seed
        pat_load     = accept_start || (word_done && last_word);
        pat_step     = word_done && !last_word;
        pat_seed     = accept_start ? seed : seed_q;
    end

    hyper_tg_pattern #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk     (clk),
        .reset_l (reset_l),
        .load    (pat_load),
        .step    (pat_step),
        .seed    (pat_seed),
        .value   (pat_val)
    );

    assign pass = done && (err_cnt == 16'd0);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q        <= StStartup;
            dly_q          <= '0;
            wd_q           <= '0;
            skip_q         <= 2'd0;
            idx_q          <= '0;
            mode_q         <= MODE_WR;
            seed_q         <= '0;
            got_rdy_q      <= 1'b0;
            stop_q         <= 1'b0;
            wr_req         <= 1'b0;
            rd_req         <= 1'b0;
            addr           <= '0;
            wr_d           <= '0;
            wr_byte_en     <= '0;
            done           <= 1'b0;
            err_cnt        <= 16'd0;
            first_err_addr <= '0;
            timeout_err    <= 1'b0;
        end else begin
            wr_req     <= 1'b0;
            rd_req     <= 1'b0;
            wr_byte_en <= '0;
            if (skip_q != 2'd0) skip_q <= skip_q - 2'd1;
            if (start && running && (mode_q == MODE_LOOP)) stop_q <= 1'b1;

            unique case (state_q)
                StStartup: begin
                    if (dly_q == DLY_LAST) state_q <= StIdle;
                    else dly_q <= dly_q + 1'b1;
                end
                StIdle, StDone: begin
                    if (start) begin
                        mode_q         <= mode;
                        seed_q         <= seed;
                        idx_q          <= '0;
                        done           <= 1'b0;
                        err_cnt        <= 16'd0;
                        first_err_addr <= '0;
                        timeout_err    <= 1'b0;
                        stop_q         <= 1'b0;
                        state_q        <= (mode == MODE_RD) ? StRdIssue : StWrIssue;
                    end
                end
                StWrIssue, StRdIssue: begin
                    if (!busy) begin
                        addr      <= ADDR_BASE + ADDR_W'(idx_q);
                        skip_q    <= 2'd2;
                        wd_q      <= '0;
                        got_rdy_q <= 1'b0;
                        if (state_q == StWrIssue) begin
                            wr_req     <= 1'b1;
                            wr_d       <= pat_val;
                            wr_byte_en <= '1;
                            state_q    <= StWrWait;
                        end else begin
                            rd_req  <= 1'b1;
                            state_q <= StRdWait;
                        end
                    end
                end
                StWrWait, StRdWait: begin
                    if (busy && (wd_q == WD_LAST)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end else if (busy) begin
                        wd_q <= wd_q + 1'b1;
                    end
                    if ((state_q == StRdWait) && rd_rdy) begin
                        got_rdy_q <= 1'b1;
                        if (rd_d != pat_val) begin
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                            if (err_cnt == 16'd0) first_err_addr <= addr;
                        end
                    end
                    if (word_done) begin
                        if (!last_word) begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= (state_q == StWrWait) ? StWrIssue : StRdIssue;
                        end else begin
                            idx_q <= '0;
                            if (state_q == StWrWait && mode_q != MODE_WR) begin
                                state_q <= StRdIssue;
                            end else if (state_q == StRdWait && mode_q == MODE_LOOP &&
                                         !stop_q && !start) begin
                                state_q <= StWrIssue;
                            end else begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end
                        end
                    end
                end
                default: state_q <= StStartup;
            endcase
        end
    end

endmodule

// File: tb/tb_hyper_traffic_gen.sv
// Directed-random bench: a memory/busy responder plus a request-sequence model
// derived from the mode rules, checked with immediate assertions.
module tb_hyper_traffic_gen;

    localparam int unsigned NW        = 4;
    localparam int unsigned START_DLY = 20;
    localparam logic [31:0] BASE      = 32'hFFFF_FFFE;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] seed = '0;
    logic        busy = 1'b0;
    logic        rd_rdy = 1'b0;
    logic [31:0] rd_d = '0;
    logic        wr_req, rd_req, done, pass, timeout_err;
    logic [31:0] addr, wr_d, first_err_addr;
    logic [3:0]  wr_byte_en;
    logic [15:0] err_cnt;

    hyper_traffic_gen #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .START_DLY (START_DLY),
        .NUM_WORDS (NW),
        .ADDR_BASE (BASE),
        .TIMEOUT   (1023)
    ) dut (
        .clk            (clk),
        .reset_l        (reset_l),
        .start          (start),
        .mode           (mode),
        .seed           (seed),
        .busy           (busy),
        .rd_rdy         (rd_rdy),
        .rd_d           (rd_d),
        .wr_req         (wr_req),
        .rd_req         (rd_req),
        .addr           (addr),
        .wr_d           (wr_d),
        .wr_byte_en     (wr_byte_en),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } req_t;

    req_t        log_q[$];
    logic [31:0] mem[logic [31:0]];
    bit          corrupt[logic [31:0]];
    int unsigned bcnt = 0;
    int unsigned hold_cnt = 0;
    bit          hold_next = 0;
    bit          both_seen = 0;
    bit          be_bad = 0;
    bit          pend_rd = 0;
    logic [31:0] pend_d = '0;
    int          n_vec = 0;
    int          n_err = 0;

    // Slave model: random busy latency, read data returned as busy drops
    initial forever begin
        @(negedge clk);
        rd_rdy = 1'b0;
        if (!reset_l) begin
            busy = 1'b0; bcnt = 0; hold_cnt = 0; pend_rd = 0;
            continue;
        end
        if (wr_req && rd_req) both_seen = 1;
        if (!wr_req && wr_byte_en != 4'h0) be_bad = 1;
        if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0 && pend_rd) begin
                rd_rdy = 1'b1; rd_d = pend_d; pend_rd = 0;
            end
        end
        if (wr_req) begin
            mem[addr] = wr_d;
            log_q.push_back('{is_wr: 1'b1, a: addr, d: wr_d, be: wr_byte_en});
            bcnt = $urandom_range(1, 4);
            if (hold_next) begin hold_next = 0; hold_cnt = 1100; end
        end else if (rd_req) begin
            pend_d = (mem.exists(addr) ? mem[addr] : 32'h0) ^
                     (corrupt.exists(addr) ? 32'h0000_0100 : 32'h0);
            pend_rd = 1;
            log_q.push_back('{is_wr: 1'b0, a: addr, d: pend_d, be: wr_byte_en});
            bcnt = $urandom_range(1, 4);
        end
        if (hold_cnt > 0) hold_cnt--;
        busy = (bcnt > 0) || (hold_cnt > 0);
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] s, input int unsigned idx);
`ifdef HYPER_TG_LFSR_EN
        logic [31:0] v;
        v = (s == 32'h0) ? 32'h1 : s;
        repeat (idx) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
        return v;
`else
        return s + 32'(idx);
`endif
    endfunction

    task automatic pulse_start(input logic [1:0] m, input logic [31:0] s);
        @(negedge clk);
        mode = m; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic new_run(input logic [1:0] m, input logic [31:0] s);
        log_q.delete();
        both_seen = 0;
        be_bad = 0;
        pulse_start(m, s);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin @(negedge clk); #1; n++; end
        check({tag, " done"}, done, 1'b1);
    endtask

    task automatic wait_reqs(input string tag, input int cnt, input int budget);
        int n = 0;
        while (log_q.size() < cnt && n < budget) begin @(negedge clk); #1; n++; end
        check({tag, " reqs seen"}, (log_q.size() >= cnt), 1'b1);
    endtask

    // Expected order: writes then reads per pass, idx = position mod NW
    task automatic check_run(input string tag, input logic [1:0] m, input logic [31:0] s,
                             input int exp_len);
        int          e_err = 0;
        logic [31:0] e_first = '0;
        check({tag, " req count"}, log_q.size(), exp_len);
        for (int p = 0; p < log_q.size() && p < exp_len; p++) begin
            int          idx;
            bit          wr_ph;
            logic [31:0] ea;
            idx   = p % NW;
            wr_ph = (m == 2'd0) || ((m >= 2'd2) && ((p % (2 * NW)) < NW));
            ea    = BASE + 32'(idx);
            check({tag, " kind"}, log_q[p].is_wr, wr_ph);
            check({tag, " addr"}, log_q[p].a, ea);
            if (wr_ph) begin
                check({tag, " wr_d"}, log_q[p].d, pat(s, idx));
                check({tag, " byte_en"}, log_q[p].be, 4'hF);
            end else if (log_q[p].d != pat(s, idx)) begin
                if (e_err == 0) e_first = ea;
                e_err++;
            end
        end
        check({tag, " err_cnt"}, err_cnt, 16'(e_err));
        check({tag, " first_err_addr"}, first_err_addr, e_first);
        check({tag, " pass"}, pass, (e_err == 0));
        check({tag, " timeout_err"}, timeout_err, 1'b0);
        check({tag, " wr+rd overlap"}, both_seen, 1'b0);
        check({tag, " stray byte_en"}, be_bad, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wr_req"}, wr_req, 1'b0);
        check({tag, " rd_req"}, rd_req, 1'b0);
        check({tag, " addr"}, addr, 32'h0);
        check({tag, " wr_d"}, wr_d, 32'h0);
        check({tag, " wr_byte_en"}, wr_byte_en, 4'h0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " pass"}, pass, 1'b0);
        check({tag, " err_cnt"}, err_cnt, 16'h0);
        check({tag, " first_err_addr"}, first_err_addr, 32'h0);
        check({tag, " timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        logic [31:0] s0, s1;
        int          ci;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset_l = 1'b1;

        // Start during the power-up delay is dropped
        repeat (4) @(negedge clk);
        new_run(2'd0, 32'h100);
        repeat (30) @(negedge clk);
        #1;
        check("startup no req", log_q.size(), 0);
        check("startup done", done, 1'b0);

        // Write-only over the wrapping window
        s0 = $urandom;
        new_run(2'd0, s0);
        wait_done("mode0", 300);
        check_run("mode0", 2'd0, s0, NW);

        // Read-check with matching seed, then with a different one
        new_run(2'd1, s0);
        check("done cleared on start", done, 1'b0);
        wait_done("mode1 same", 300);
        check_run("mode1 same", 2'd1, s0, NW);
        s1 = s0 + 32'($urandom_range(1, 1000));
        new_run(2'd1, s1);
        wait_done("mode1 diff", 300);
        check_run("mode1 diff", 2'd1, s1, NW);

        // Write-then-verify with a corrupting memory; start mid-run ignored
        s0 = $urandom;
        ci = $urandom_range(0, NW - 1);
        corrupt[BASE + 32'(ci)] = 1;
        corrupt[BASE + 32'($urandom_range(0, NW - 1))] = 1;
        new_run(2'd2, s0);
        repeat (5) @(negedge clk);
        pulse_start(2'd0, 32'h0);
        wait_done("mode2", 400);
        check_run("mode2", 2'd2, s0, 2 * NW);
        corrupt.delete();

        // Loop mode, stopped by a start pulse during the second pass
        s0 = $urandom;
        corrupt[BASE + 32'($urandom_range(0, NW - 1))] = 1;
        new_run(2'd3, s0);
        wait_reqs("loop", 2 * NW + 2, 500);
        pulse_start(2'd3, s0);
        wait_done("loop", 500);
        check_run("loop", 2'd3, s0, 4 * NW);
        corrupt.delete();

        // Busy stuck high after the first write
        hold_next = 1;
        new_run(2'd0, $urandom);
        wait_done("timeout", 1500);
        check("timeout flag", timeout_err, 1'b1);
        check("timeout reqs", log_q.size(), 1);
        repeat (200) @(negedge clk);
        #1;
        check("timeout no further req", log_q.size(), 1);
        check("timeout busy released", busy, 1'b0);

        // Reset while a read is outstanding
        new_run(2'd1, $urandom);
        wait_reqs("abort", 1, 100);
        check("abort rd_req seen", rd_req, 1'b1);
        reset_l = 1'b0;
        #1;
        check_all_zero("abort");
        log_q.delete();
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("abort startup quiet", log_q.size(), 0);
        repeat (10) @(negedge clk);
        s0 = $urandom;
        new_run(2'd2, s0);
        wait_done("after abort", 400);
        check_run("after abort", 2'd2, s0, 2 * NW);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hyper_traffic_gen.md
Name: hyper_traffic_gen

Overview:
Parametrised traffic generator and checker for the HyperRAM interface block `hyper_xface`. It replaces the hand-written write-increment loop with a synthesizable engine.
- Waits out the power-up delay, then issues single-word write and/or read requests over a programmable address window.
- Checks read data against a regenerated pattern and reports pass/fail with an error count.
- Sits between board-level control (buttons/UART/test top) and the hyper_xface request port; usable in simulation and on hardware.

Parameters:
- ADDR_W, 32, width of addr port.
- DATA_W, 32, width of wr_d/rd_d; multiple of 8.
- START_DLY, 2000, cycles after reset before first request (150 us at 12 MHz plus margin).
- NUM_WORDS, 256, words per pass; >=1.
- ADDR_BASE, 0, first address of the window.
- TIMEOUT, 1023, max cycles busy may stay high per transaction.

Ports:
- clk, in, 1, single clock.
- reset_l, in, 1, reset, asynchronous, active-low.
- start, in, 1, one-cycle pulse; begins a run.
- mode, in, 2, 0=write-only, 1=read-check only, 2=write-then-verify, 3=loop write-then-verify until start pulses again.
- seed, in, DATA_W, pattern seed, sampled on accepted start.
- busy, in, 1, from hyper_xface.
- rd_rdy, in, 1, one-cycle read-data valid from hyper_xface.
- rd_d, in, DATA_W, read data.
- wr_req, out, 1, one-cycle write request.
- rd_req, out, 1, one-cycle read request.
- addr, out, ADDR_W, request address.
- wr_d, out, DATA_W, write data.
- wr_byte_en, out, DATA_W/8, all ones during writes, zero otherwise.
- done, out, 1, high from end of run until next accepted start.
- pass, out, 1, done && err_cnt==0.
- err_cnt, out, 16, mismatches; saturates at 16'hFFFF.
- first_err_addr, out, ADDR_W, address of first mismatch.
- timeout_err, out, 1, sticky; set if busy exceeds TIMEOUT.

Behaviour:
- Reset (reset_l low, async): all outputs 0; state STARTUP; delay counter cleared. Reset mid-run aborts with no further requests; STARTUP re-runs.
- STARTUP: count START_DLY cycles, then IDLE. A start pulse in STARTUP is dropped.
- IDLE: start=1 latches mode and seed, sets idx=0, clears done/err_cnt/first_err_addr/timeout_err. Goes to WR_ISSUE if mode!=1, else RD_ISSUE.
- Request issue: only when busy==0. Drive addr=ADDR_BASE+idx, with wr_d=pattern(idx) for writes. Pulse wr_req or rd_req for exactly one cycle; addr/wr_d are stable that cycle and held until the next issue. Never assert wr_req and rd_req together.
- WR_WAIT / RD_WAIT:
  - Ignore busy for the cycle after the pulse, then wait for busy==0.
  - RD_WAIT also requires one rd_rdy before leaving. rd_d is compared with pattern(idx) in the rd_rdy cycle.
  - On mismatch, err_cnt increments; if it was 0, first_err_addr is set to the current addr.
- Watchdog: counts cycles with busy high in a WAIT state. At TIMEOUT it sets timeout_err, terminates the run and goes to DONE.
- Sequencing: after each word, idx+1. When idx==NUM_WORDS-1 completes:
  - Write phase ends to RD_ISSUE with idx=0 for modes 2/3, or to DONE for mode 0.
  - Read phase ends to DONE (modes 1/2) or back to WR_ISSUE with idx=0 (mode 3; err_cnt accumulates).
  - A start pulse in mode 3 ends the loop at the end of the current pass.
- Address arithmetic is modulo 2^ADDR_W; a window that crosses the top wraps to 0.
- Pattern (default): seed+idx, modulo 2^DATA_W.
- DONE: done=1, pass valid; a new start behaves as in IDLE.
- start during a non-loop run is ignored.

Optional Feature:
HYPER_TG_LFSR_EN
- Defined: pattern(idx) is a maximal-length Galois LFSR, DATA_W wide, loaded with seed (seed 0 forced to 1) and advanced once per word. The read phase reloads seed and replays the sequence.
- Undefined: the incrementing pattern is used and no LFSR logic is generated.

Decomposition:
- Package hyper_tg_pkg: state encoding (STARTUP, IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE), mode constants (MODE_WR, MODE_RD, MODE_WRV, MODE_LOOP), and LFSR tap constants per supported DATA_W (16/32/64).
- One sub-module, hyper_tg_pattern: load/step/value interface, holding the increment or LFSR logic.

Test Plan:
- START_DLY=20; pulse start in cycle 5 -> ignored, no req before cycle 20.
- mode 0, NUM_WORDS=4, seed=0x100, busy model 3 cycles -> 4 wr_req pulses at addr 0..3 with wr_d 0x100..0x103, then done=1, pass=1.
- mode 2 with a memory model that corrupts addr 2 -> err_cnt=1, first_err_addr=2, pass=0.
- Hold busy high 1100 cycles after a wr_req -> timeout_err=1, done=1, no further requests.
- Assert reset_l low mid-RD_WAIT -> outputs 0 immediately; STARTUP re-runs; a new start completes normally.
- ADDR_BASE=2^ADDR_W-2, NUM_WORDS=4, mode 2 -> addresses FFFF_FFFE, FFFF_FFFF, 0, 1; pass=1.
